// File: rtl/tone_quad_meter.sv
// Tone frequency meter: counts signed quarter-turn steps of an NCO sin/cos pair
// over windows of 2^WIN_LOG2 valid samples and reports the implied phase increment.
module tone_quad_meter #(
    parameter int WIN_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clken,
    input  logic        meas_en,
    input  logic        in_valid,
    input  logic [15:0] fsin_i,
    input  logic [15:0] fcos_i,
    output logic [31:0] phi_est_o,
    output logic        out_valid,
    output logic        err_o
);
    localparam int ACC_W = WIN_LOG2 + 2;
    localparam int SHIFT = 30 - WIN_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_COUNT = 2'd2
    } state_t;

    // Quadrant code chosen so that forward rotation increments it modulo 4.
    function automatic logic [1:0] quadrant(input logic [15:0] s, input logic [15:0] c);
        logic sin_neg;
        logic cos_neg;
        sin_neg = ($signed(s) < 16'sd0);
        cos_neg = ($signed(c) < 16'sd0);
        return {sin_neg, sin_neg ^ cos_neg};
    endfunction

    function automatic logic signed [ACC_W-1:0] quad_step(input logic [1:0] d);
        case (d)
            2'd1:    return ACC_W'(1);
            2'd3:    return {ACC_W{1'b1}};
            default: return {ACC_W{1'b0}};
        endcase
    endfunction

    state_t                    state_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [WIN_LOG2-1:0]       cnt_q;
    logic [1:0]                qprev_q;
    logic                      werr_q;
    logic [31:0]               phi_q;
    logic                      ov_q;
    logic                      err_q;

    logic [1:0]                q_new_s;
    logic [1:0]                d_s;
    logic signed [ACC_W-1:0]   acc_d;
    logic [WIN_LOG2-1:0]       cnt_d;
    logic                      werr_d;
    logic                      last_s;
    logic signed [31:0]        acc_ext_s;
    logic [31:0]               phi_d;

    // Per-sample step decode and next accumulator/report value.
    always_comb begin
        q_new_s   = quadrant(fsin_i, fcos_i);
        d_s       = q_new_s - qprev_q;
        acc_d     = acc_q + quad_step(d_s);
        cnt_d     = cnt_q + WIN_LOG2'(1);
        werr_d    = werr_q | (d_s == 2'd2);
        last_s    = (cnt_q == {WIN_LOG2{1'b1}});
        acc_ext_s = 32'(acc_d);
        phi_d     = acc_ext_s <<< SHIFT;
    end

    // Measurement FSM with registered report outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= {WIN_LOG2{1'b0}};
            qprev_q <= 2'd0;
            werr_q  <= 1'b0;
            phi_q   <= 32'd0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (clken) begin
            ov_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (meas_en) begin
                        state_q <= ST_PRIME;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_PRIME: begin
                    if (!meas_en) begin
                        state_q <= ST_IDLE;
                    end else if (in_valid) begin
                        qprev_q <= q_new_s;
                        acc_q   <= {ACC_W{1'b0}};
                        cnt_q   <= {WIN_LOG2{1'b0}};
                        werr_q  <= 1'b0;
                        state_q <= ST_COUNT;
                    end else begin
                        state_q <= ST_PRIME;
                    end
                end
                ST_COUNT: begin
                    // The closing sample also seeds the next window, so no re-prime.
                    if (in_valid && last_s) begin
                        phi_q   <= phi_d;
                        err_q   <= werr_d;
                        ov_q    <= 1'b1;
                        qprev_q <= q_new_s;
                        acc_q   <= {ACC_W{1'b0}};
                        cnt_q   <= {WIN_LOG2{1'b0}};
                        werr_q  <= 1'b0;
                        state_q <= meas_en ? ST_COUNT : ST_IDLE;
                    end else if (!meas_en) begin
                        state_q <= ST_IDLE;
                    end else if (in_valid) begin
                        acc_q   <= acc_d;
                        cnt_q   <= cnt_d;
                        qprev_q <= q_new_s;
                        werr_q  <= werr_d;
                        state_q <= ST_COUNT;
                    end else begin
                        state_q <= ST_COUNT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end else begin
            state_q <= state_q;
        end
    end

    assign phi_est_o = phi_q;
    assign out_valid = ov_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_tone_quad_meter.sv
// Scoreboard bench: stimulus pushes expected reports, negedge monitors pop and compare.
module tb_tone_quad_meter;
    logic        clk = 1'b0;
    logic        reset_n, clken;
    logic        meas_en4, in_valid4, meas_en10, in_valid10;
    logic [15:0] fsin4, fcos4, fsin10, fcos10;
    logic [31:0] phi4, phi10;
    logic        ov4, err4, ov10, err10;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] phi;
        logic        err;
    } exp_t;

    exp_t        q4[$];
    logic [31:0] q10[$];
    exp_t        e4;
    logic [31:0] t10;
    longint      sum10 = 0;
    longint      diff10;
    logic        prev_rep4 = 1'b0;
    logic        alt4 = 1'b0;

    localparam logic [63:0] NCO_INC = 64'h0000_0000_0088_8889;
    localparam logic [63:0] NCO_P0  = 64'h0000_0000_1234_5678;

    always #5 clk = ~clk;

    tone_quad_meter #(.WIN_LOG2(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .meas_en(meas_en4),
        .in_valid(in_valid4), .fsin_i(fsin4), .fcos_i(fcos4),
        .phi_est_o(phi4), .out_valid(ov4), .err_o(err4)
    );

    tone_quad_meter #(.WIN_LOG2(10)) dut10 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .meas_en(meas_en10),
        .in_valid(in_valid10), .fsin_i(fsin10), .fcos_i(fcos10),
        .phi_est_o(phi10), .out_valid(ov10), .err_o(err10)
    );

    // Monitor for the WIN_LOG2=4 instance: report compare plus pulse-width check.
    always @(negedge clk) begin
        if (prev_rep4) begin
            vectors++;
            if (ov4 !== 1'b0) begin
                miscompares++;
                $display("FAIL pulse_width: out_valid=%0b, required 0 after one enabled cycle", ov4);
            end
        end
        prev_rep4 = ov4 && clken;
        if (ov4 && clken) begin
            vectors++;
            if (q4.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_report: phi=%08h err=%0b, required no out_valid", phi4, err4);
            end else begin
                e4 = q4.pop_front();
                if (phi4 !== e4.phi || err4 !== e4.err) begin
                    miscompares++;
                    $display("FAIL report4: phi=%08h err=%0b, required phi=%08h err=%0b",
                             phi4, err4, e4.phi, e4.err);
                end
            end
        end
    end

    // Monitor for the WIN_LOG2=10 instance: tolerance compare and running step total.
    always @(negedge clk) begin
        if (ov10 && clken) begin
            vectors++;
            if (q10.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_report10: phi=%08h, required no out_valid", phi10);
            end else begin
                t10    = q10.pop_front();
                diff10 = longint'($signed(phi10)) - longint'(t10);
                sum10  = sum10 + longint'($signed(phi10) >>> 20);
                if (diff10 > 64'sh100000 || diff10 < -64'sh100000 || err10 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL report10: phi=%08h err=%0b, required %08h +-00100000 err=0",
                             phi10, err10, t10);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] qval(input logic [1:0] q, input logic alt);
        case (q)
            2'd0:    return alt ? {16'sd0, 16'sd0}           : {16'sd1200, 16'sd3000};
            2'd1:    return alt ? {16'sd0, -16'sd1}          : {16'sd2000, -16'sd500};
            2'd2:    return alt ? {-16'sd32768, -16'sd32768} : {-16'sd700, -16'sd900};
            default: return alt ? {-16'sd1, 16'sd0}          : {-16'sd3000, 16'sd100};
        endcase
    endfunction

    task automatic send4(input logic [1:0] q);
        {fsin4, fcos4} = qval(q, alt4);
        alt4      = ~alt4;
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
    endtask

    task automatic expect4(input logic [31:0] phi, input logic err);
        q4.push_back({phi, err});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    int           seq_c[16] = '{1,2,3,0,2,3,0,1,2,3,0,1,2,3,0,1};
    int           seq_d[16] = '{1,1,1,1,2,3,0,1,2,3,0,1,0,3,2,1};
    logic [1:0]   cur;
    logic [63:0]  pu;
    longint       exp_total;

    initial begin
        reset_n = 1'b0; clken = 1'b0;
        meas_en4 = 1'b0; in_valid4 = 1'b0; fsin4 = 16'd0; fcos4 = 16'd0;
        meas_en10 = 1'b0; in_valid10 = 1'b0; fsin10 = 16'd0; fcos10 = 16'd0;
        tick(); tick();
        check("reset_phi4", phi4, 32'd0);
        check("reset_ov4", {31'd0, ov4}, 32'd0);
        check("reset_err4", {31'd0, err4}, 32'd0);
        check("reset_phi10", phi10, 32'd0);
        check("reset_ov10", {31'd0, ov10}, 32'd0);
        reset_n = 1'b1; clken = 1'b1;
        tick();

        // Forward quarter steps: +16 -> 0x40000000.
        meas_en4 = 1'b1;
        tick();
        send4(2'd0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) expect4(32'h4000_0000, 1'b0);
            send4(2'(i % 4));
        end
        // Backward, back to back: -16 -> 0xC0000000.
        cur = 2'd0;
        for (int i = 1; i <= 16; i++) begin
            cur = cur + 2'd3;
            if (i == 16) expect4(32'hC000_0000, 1'b0);
            send4(cur);
        end
        // One Q0->Q2 jump: 15 forward steps, error flagged.
        for (int i = 0; i < 16; i++) begin
            if (i == 15) expect4(32'h3C00_0000, 1'b1);
            send4(2'(seq_c[i]));
        end
        // Gapped valids and a frozen-clock burst: net +4, error cleared.
        for (int i = 0; i < 16; i++) begin
            if (i == 15) expect4(32'h1000_0000, 1'b0);
            send4(2'(seq_d[i]));
            if (i == 7) begin
                clken = 1'b0;
                {fsin4, fcos4} = qval(2'd2, 1'b0);
                in_valid4 = 1'b1;
                tick(); tick(); tick();
                in_valid4 = 1'b0;
                clken = 1'b1;
            end
            if (i == 15) begin
                clken = 1'b0;
                tick(); tick();
                clken = 1'b1;
            end
            tick();
        end
        // Final sample coincides with meas_en drop: report still issued.
        cur = 2'd1;
        for (int i = 1; i <= 16; i++) begin
            cur = cur + 2'd1;
            if (i == 16) begin
                meas_en4 = 1'b0;
                expect4(32'h4000_0000, 1'b0);
            end
            send4(cur);
        end
        tick(); tick(); tick();
        check("hold_phi4", phi4, 32'h4000_0000);
        check("hold_err4", {31'd0, err4}, 32'd0);

        // Partial window abandoned via meas_en, then via reset.
        meas_en4 = 1'b1;
        tick();
        send4(2'd0);
        for (int i = 1; i <= 8; i++) send4(2'(i % 4));
        meas_en4 = 1'b0;
        send4(2'd1);
        tick(); tick();
        meas_en4 = 1'b1;
        tick();
        send4(2'd0);
        for (int i = 1; i <= 8; i++) send4(2'(i % 4));
        reset_n = 1'b0; clken = 1'b0;
        tick();
        reset_n = 1'b1; clken = 1'b1;
        check("post_reset_phi4", phi4, 32'd0);
        check("post_reset_ov4", {31'd0, ov4}, 32'd0);
        check("post_reset_err4", {31'd0, err4}, 32'd0);
        tick();
        send4(2'd2);
        cur = 2'd2;
        for (int i = 1; i <= 16; i++) begin
            cur = cur + 2'd3;
            if (i == 16) expect4(32'hC000_0000, 1'b0);
            send4(cur);
        end
        meas_en4 = 1'b0;
        tick(); tick();

        // NCO-driven long windows, three back to back.
        meas_en10 = 1'b1;
        tick();
        pu = NCO_P0;
        for (int n = 0; n <= 3072; n++) begin
            fsin10 = pu[31] ? -16'sd5000 : 16'sd5000;
            fcos10 = (pu[31] ^ pu[30]) ? -16'sd5000 : 16'sd5000;
            if (n == 1024 || n == 2048 || n == 3072) q10.push_back(32'h0088_8889);
            in_valid10 = 1'b1;
            tick();
            pu = pu + NCO_INC;
        end
        in_valid10 = 1'b0;
        meas_en10 = 1'b0;

        for (int k = 0; k < 50 && (q4.size() != 0 || q10.size() != 0); k++) tick();
        vectors++;
        if (q4.size() != 0 || q10.size() != 0) begin
            miscompares++;
            $display("FAIL missing_reports: pending %0d/%0d, required 0/0", q4.size(), q10.size());
        end
        exp_total = longint'((NCO_P0 + 64'd3072 * NCO_INC) >> 30) - longint'(NCO_P0 >> 30);
        vectors++;
        if (sum10 != exp_total) begin
            miscompares++;
            $display("FAIL nco_total_steps: got %0d, required %0d", sum10, exp_total);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
